histogram_peak_reader: RTL and testbench

//  Consumer end of the histogramTop readout interface. On start (driven from filterDone) it

---
 rtl/histogram_peak_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_histogram_peak_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_peak_reader.sv
// histogram_peak_reader
//
// Readout stage between the median filter / histogram core (histogramTop) and
// the downstream tracking logic. A start request issues a one-cycle
// readHistogram as soon as histogramTop reports ready. The block then collects
// the X and Y bin streams and keeps, per axis, the first maximum bin (index and
// count) and a saturating total. When both streams are complete it issues a
// one-cycle clearHistogram and waits for the histogramClear strobe before
// presenting the results. If either wait stalls for TIMEOUT cycles, the
// operation is abandoned with a sticky timeoutError.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             single-cycle read request, accepted in IDLE/DONE only
//   ready             histogramTop idle; gates readHistogram
//   readHistogram     one-cycle read request to histogramTop (registered)
//   clearHistogram    one-cycle clear request to histogramTop (registered)
//   xHistogramOut     X bin count, qualified by xValid (bins 0..X_BINS-1)
//   xValid            X beat valid
//   yHistogramOut     Y bin count, qualified by yValid (bins 0..Y_BINS-1)
//   yValid            Y beat valid
//   histogramClear    clear-complete strobe from histogramTop
//   xPeakIndex/Value  first maximum X bin and its count
//   yPeakIndex/Value  first maximum Y bin and its count
//   xTotal, yTotal    saturating sums of all bins per axis
//   busy              high in REQ, COLLECT, CLEAR, WAIT_CLR
//   resultValid       high in DONE; results stable while high
//   timeoutError      sticky abort flag, cleared by the next accepted start

module histogram_peak_reader #(
    parameter int X_BINS  = 240,
    parameter int Y_BINS  = 180,
    parameter int CNT_W   = 8,
    parameter int SUM_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ready,
    output logic             readHistogram,
    output logic             clearHistogram,
    input  logic [CNT_W-1:0] xHistogramOut,
    input  logic             xValid,
    input  logic [CNT_W-1:0] yHistogramOut,
    input  logic             yValid,
    input  logic             histogramClear,
    output logic [CNT_W-1:0] xPeakIndex,
    output logic [CNT_W-1:0] xPeakValue,
    output logic [CNT_W-1:0] yPeakIndex,
    output logic [CNT_W-1:0] yPeakValue,
    output logic [SUM_W-1:0] xTotal,
    output logic [SUM_W-1:0] yTotal,
    output logic             busy,
    output logic             resultValid,
    output logic             timeoutError
);

    localparam int XC_W = $clog2(X_BINS + 1);
    localparam int YC_W = $clog2(Y_BINS + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        CLEAR,
        WAIT_CLR,
        DONE
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [XC_W-1:0] xBeatCount;
    logic [YC_W-1:0] yBeatCount;
    logic [TO_W-1:0] idleCount;
    logic            xAccept;
    logic            yAccept;
    logic            streamsComplete;
    logic            idleExpired;
    logic            timedState;
    logic            acceptStart;
    logic            timeoutHit;
    logic            readNext;
    logic            clearNext;

    // Adds one bin count to a running total, pinning at all-ones instead of
    // wrapping so an overflowing axis still reports "very large".
    function automatic logic [SUM_W-1:0] satAdd(input logic [SUM_W-1:0] total,
                                                 input logic [CNT_W-1:0] value);
        logic [SUM_W:0] sum;
        sum = {1'b0, total} + (SUM_W + 1)'(value);
        return sum[SUM_W] ? '1 : sum[SUM_W-1:0];
    endfunction

    // Beats count only while collecting and only up to the expected bin count;
    // surplus beats from an over-long stream are dropped.
    assign xAccept         = (state == COLLECT) && xValid && (xBeatCount < XC_W'(X_BINS));
    assign yAccept         = (state == COLLECT) && yValid && (yBeatCount < YC_W'(Y_BINS));
    assign streamsComplete = (xBeatCount == XC_W'(X_BINS)) && (yBeatCount == YC_W'(Y_BINS));
    assign idleExpired     = (idleCount == TO_W'(TIMEOUT));
    assign timedState      = (state == COLLECT) || (state == WAIT_CLR);

    assign busy        = (state == REQ) || (state == COLLECT) || (state == CLEAR) || (state == WAIT_CLR);
    assign resultValid = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and pulse decode. readHistogram is raised in the cycle after
    // ready is sampled high; while it is high the FSM moves on to COLLECT, so
    // it can never last more than one cycle. clearHistogram is raised exactly
    // on entry to CLEAR, which also keeps the two requests mutually exclusive.
    always_comb begin
        nextState   = state;
        acceptStart = 1'b0;
        timeoutHit  = 1'b0;
        readNext    = 1'b0;
        clearNext   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    acceptStart = 1'b1;
                    readNext    = ready;
                    nextState   = REQ;
                end
            end
            REQ: begin
                if (readHistogram) begin
                    nextState = COLLECT;
                end else if (ready) begin
                    readNext = 1'b1;
                end
            end
            COLLECT: begin
                if (streamsComplete) begin
                    clearNext = 1'b1;
                    nextState = CLEAR;
                end else if (idleExpired) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
            end
            CLEAR: begin
                nextState = histogramClear ? DONE : WAIT_CLR;
            end
            WAIT_CLR: begin
                if (histogramClear) begin
                    nextState = DONE;
                end else if (idleExpired) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Registered request pulses and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readHistogram  <= 1'b0;
            clearHistogram <= 1'b0;
            timeoutError   <= 1'b0;
        end else begin
            readHistogram  <= readNext;
            clearHistogram <= clearNext;
            if (acceptStart) begin
                timeoutError <= 1'b0;
            end else if (timeoutHit) begin
                timeoutError <= 1'b1;
            end
        end
    end

    // Idle watchdog: counts only in the two states that wait on histogramTop,
    // and restarts on any accepted beat or whenever the FSM changes state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idleCount <= '0;
        end else if (!timedState || (nextState != state) || xAccept || yAccept) begin
            idleCount <= '0;
        end else begin
            idleCount <= idleCount + TO_W'(1);
        end
    end

    // X axis: bin 0 always loads the peak; later bins replace it only when
    // strictly larger, so ties keep the earliest index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xBeatCount <= '0;
            xPeakIndex <= '0;
            xPeakValue <= '0;
            xTotal     <= '0;
        end else if (acceptStart) begin
            xBeatCount <= '0;
            xPeakIndex <= '0;
            xPeakValue <= '0;
            xTotal     <= '0;
        end else if (xAccept) begin
            xBeatCount <= xBeatCount + XC_W'(1);
            if ((xBeatCount == '0) || (xHistogramOut > xPeakValue)) begin
                xPeakValue <= xHistogramOut;
                xPeakIndex <= CNT_W'(xBeatCount);
            end
            xTotal <= satAdd(xTotal, xHistogramOut);
        end
    end

    // Y axis: same peak/total rules as X, independent stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            yBeatCount <= '0;
            yPeakIndex <= '0;
            yPeakValue <= '0;
            yTotal     <= '0;
        end else if (acceptStart) begin
            yBeatCount <= '0;
            yPeakIndex <= '0;
            yPeakValue <= '0;
            yTotal     <= '0;
        end else if (yAccept) begin
            yBeatCount <= yBeatCount + YC_W'(1);
            if ((yBeatCount == '0) || (yHistogramOut > yPeakValue)) begin
                yPeakValue <= yHistogramOut;
                yPeakIndex <= CNT_W'(yBeatCount);
            end
            yTotal <= satAdd(yTotal, yHistogramOut);
        end
    end

endmodule

// File: tb/tb_histogram_peak_reader.sv
// tb_histogram_peak_reader
//
// Directed bench for histogram_peak_reader. Each frame loads bin tables,
// runs start -> read -> stream -> clear handshake, and compares the peak and
// total outputs with hand-computed values. SUM_W is narrowed to 15 so that
// total saturation is reachable with 8-bit bins.

module tb_histogram_peak_reader;

    localparam int X_BINS  = 240;
    localparam int Y_BINS  = 180;
    localparam int CNT_W   = 8;
    localparam int SUM_W   = 15;
    localparam int TIMEOUT = 4096;

    logic             clk;
    logic             reset;
    logic             start;
    logic             ready;
    logic             readHistogram;
    logic             clearHistogram;
    logic [CNT_W-1:0] xHistogramOut;
    logic             xValid;
    logic [CNT_W-1:0] yHistogramOut;
    logic             yValid;
    logic             histogramClear;
    logic [CNT_W-1:0] xPeakIndex;
    logic [CNT_W-1:0] xPeakValue;
    logic [CNT_W-1:0] yPeakIndex;
    logic [CNT_W-1:0] yPeakValue;
    logic [SUM_W-1:0] xTotal;
    logic [SUM_W-1:0] yTotal;
    logic             busy;
    logic             resultValid;
    logic             timeoutError;

    int checkCount  = 0;
    int errorCount  = 0;
    int clearTotal  = 0;
    int overlapTotal = 0;
    int xBins[256];
    int yBins[256];

    histogram_peak_reader #(
        .X_BINS (X_BINS),
        .Y_BINS (Y_BINS),
        .CNT_W  (CNT_W),
        .SUM_W  (SUM_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ready         (ready),
        .readHistogram (readHistogram),
        .clearHistogram(clearHistogram),
        .xHistogramOut (xHistogramOut),
        .xValid        (xValid),
        .yHistogramOut (yHistogramOut),
        .yValid        (yValid),
        .histogramClear(histogramClear),
        .xPeakIndex    (xPeakIndex),
        .xPeakValue    (xPeakValue),
        .yPeakIndex    (yPeakIndex),
        .yPeakValue    (yPeakValue),
        .xTotal        (xTotal),
        .yTotal        (yTotal),
        .busy          (busy),
        .resultValid   (resultValid),
        .timeoutError  (timeoutError)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (clearHistogram) clearTotal++;
        if (clearHistogram && readHistogram) overlapTotal++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start and follows the read request into COLLECT. With readyLow>0,
    // ready is held off for that many cycles and a stray start is injected.
    task automatic beginFrame(input int readyLow);
        int badRead;
        ready = (readyLow == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (readyLow == 0) begin
            checkOutput("readAtNplus1", readHistogram, 1);
        end else begin
            badRead = 0;
            for (int k = 0; k < readyLow; k++) begin
                if (readHistogram) badRead++;
                start = (k == 5);
                tick();
            end
            start = 1'b0;
            checkOutput("readHeldOff", badRead, 0);
            checkOutput("busyWaitReady", busy, 1);
            ready = 1'b1;
            tick();
            checkOutput("readAfterReady", readHistogram, 1);
        end
        tick();
        checkOutput("readOnePulse", readHistogram, 0);
    endtask

    // Streams the bin tables (mode 0: X and Y concurrent, mode 1: X then Y),
    // answers clearHistogram with histogramClear clrDelay cycles later, and
    // optionally pulses start at loop cycle midStart.
    task automatic applyStimulus(input int nX, input int nY, input int clrDelay,
                                 input int mode, input int midStart);
        int xi;
        int yi;
        int sinceClr;
        int clearBase;
        logic hcNow;
        logic finished;
        xi        = 0;
        yi        = 0;
        sinceClr  = -1;
        finished  = 1'b0;
        clearBase = clearTotal;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            xValid        = (xi < nX);
            yValid        = (yi < nY) && ((mode == 0) || (xi >= nX));
            xHistogramOut = xValid ? CNT_W'(xBins[xi]) : '0;
            yHistogramOut = yValid ? CNT_W'(yBins[yi]) : '0;
            start         = (cyc == midStart);
            hcNow         = (sinceClr == clrDelay);
            histogramClear = hcNow;
            if (hcNow) checkOutput("rvBeforeClr", resultValid, 0);
            tick();
            if (xValid) xi++;
            if (yValid) yi++;
            if (hcNow) begin
                finished = 1'b1;
                break;
            end
            if (sinceClr >= 0) sinceClr++;
            else if (clearHistogram) sinceClr = 0;
        end
        start          = 1'b0;
        xValid         = 1'b0;
        yValid         = 1'b0;
        histogramClear = 1'b0;
        checkOutput("frameFinished", finished, 1);
        checkOutput("rvAfterClr", resultValid, 1);
        checkOutput("clearPulses", clearTotal - clearBase, 1);
    endtask

    task automatic checkResults(input int xi, input int xv, input int yi, input int yv,
                                input int xt, input int yt);
        checkOutput("xPeakIndex", xPeakIndex, xi);
        checkOutput("xPeakValue", xPeakValue, xv);
        checkOutput("yPeakIndex", yPeakIndex, yi);
        checkOutput("yPeakValue", yPeakValue, yv);
        checkOutput("xTotal", xTotal, xt);
        checkOutput("yTotal", yTotal, yt);
        checkOutput("busyDone", busy, 0);
    endtask

    initial begin
        int waited;
        int clearBase;
        reset          = 1'b0;
        start          = 1'b0;
        ready          = 1'b1;
        xValid         = 1'b0;
        yValid         = 1'b0;
        xHistogramOut  = '0;
        yHistogramOut  = '0;
        histogramClear = 1'b0;

        // Test 1: reset held against random activity, then start and async reset.
        for (int i = 0; i < 8; i++) begin
            xValid         = 1'($urandom_range(0, 1));
            yValid         = 1'($urandom_range(0, 1));
            xHistogramOut  = 8'($urandom_range(0, 255));
            yHistogramOut  = 8'($urandom_range(0, 255));
            start          = 1'($urandom_range(0, 1));
            histogramClear = 1'($urandom_range(0, 1));
            tick();
        end
        checkOutput("rstRead", readHistogram, 0);
        checkOutput("rstClear", clearHistogram, 0);
        checkOutput("rstXPeak", {xPeakIndex, xPeakValue}, 0);
        checkOutput("rstYPeak", {yPeakIndex, yPeakValue}, 0);
        checkOutput("rstTotals", {xTotal, yTotal}, 0);
        checkOutput("rstStatus", {busy, resultValid, timeoutError}, 0);
        xValid = 1'b0; yValid = 1'b0; start = 1'b0; histogramClear = 1'b0;
        xHistogramOut = '0; yHistogramOut = '0;
        reset = 1'b1;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("firstReadNplus1", readHistogram, 1);
        checkOutput("busyAfterStart", busy, 1);
        reset = 1'b0;
        #1;
        checkOutput("asyncRstRead", readHistogram, 0);
        checkOutput("asyncRstBusy", busy, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Test 2: X ramp i%200, Y flat 7 with a 255 spike at bin 90 (X then Y).
        for (int i = 0; i < 256; i++) begin
            xBins[i] = i % 200;
            yBins[i] = (i == 90) ? 255 : 7;
        end
        beginFrame(0);
        applyStimulus(X_BINS, Y_BINS, 1, 1, -1);
        // xTotal = sum(0..199) + sum(0..39); yTotal = 179*7 + 255
        checkResults(199, 199, 90, 255, 20680, 1508);

        // Test 3: all-zero X, tied Y peaks at bins 5 and 100; clear strobe in CLEAR cycle.
        for (int i = 0; i < 256; i++) begin
            xBins[i] = 0;
            yBins[i] = (i == 5 || i == 100) ? 50 : 0;
        end
        beginFrame(0);
        applyStimulus(X_BINS, Y_BINS, 0, 0, -1);
        checkResults(0, 0, 5, 50, 0, 100);
        for (int i = 0; i < 3; i++) begin
            xValid = 1'b1; xHistogramOut = 8'd200;
            yValid = 1'b1; yHistogramOut = 8'd200;
            tick();
        end
        xValid = 1'b0; yValid = 1'b0;
        checkOutput("doneIgnoresBeats", {xPeakValue, yPeakValue, xTotal}, {8'd0, 8'd50, 15'd0});
        checkOutput("doneHolds", resultValid, 1);

        // Test 4: concurrent streams, 3 surplus X beats of 255, clear answered 4 cycles late.
        for (int i = 0; i < 256; i++) begin
            xBins[i] = (i >= X_BINS) ? 255 : ((i == 17 || i == 230) ? 100 : 10);
            yBins[i] = i % 50;
        end
        beginFrame(0);
        applyStimulus(X_BINS + 3, Y_BINS, 4, 0, -1);
        // xTotal = 238*10 + 2*100; yTotal = 3*sum(0..49) + sum(0..29)
        checkResults(17, 100, 49, 49, 2580, 4110);

        // Test 5: Y stalls after 100 beats -> watchdog abort, no clear request.
        for (int i = 0; i < 256; i++) begin
            xBins[i] = 0;
            yBins[i] = 0;
        end
        clearBase = clearTotal;
        beginFrame(0);
        for (int i = 0; i < X_BINS; i++) begin
            xValid = 1'b1;
            yValid = (i < 100);
            tick();
        end
        xValid = 1'b0;
        yValid = 1'b0;
        waited = 0;
        while (!timeoutError && waited < TIMEOUT + 50) begin
            tick();
            waited++;
        end
        checkOutput("timeoutFlag", timeoutError, 1);
        checkOutput("timeoutWindow", (waited >= TIMEOUT - 1) && (waited <= TIMEOUT + 2), 1);
        checkOutput("timeoutIdle", {busy, resultValid}, 0);
        checkOutput("noClearOnTimeout", clearTotal - clearBase, 0);

        // Test 6: ready low for 20 cycles, stray starts in REQ and mid-COLLECT ignored.
        for (int i = 0; i < 256; i++) begin
            xBins[i] = (i < X_BINS) ? 255 - i : 0;
            yBins[i] = 1;
        end
        beginFrame(20);
        checkOutput("timeoutCleared", timeoutError, 0);
        applyStimulus(X_BINS, Y_BINS, 2, 1, 100);
        // xTotal = sum(16..255)
        checkResults(0, 255, 0, 1, 32520, 180);

        // Test 7: totals saturate at 2^15-1.
        for (int i = 0; i < 256; i++) begin
            xBins[i] = 255;
            yBins[i] = 200;
        end
        beginFrame(0);
        applyStimulus(X_BINS, Y_BINS, 1, 0, -1);
        checkResults(0, 255, 0, 200, 32767, 32767);

        checkOutput("readClearOverlap", overlapTotal, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
